// File: rtl/wb_ddr_arbiter.sv
// Two-master Wishbone B3 arbiter in front of the single DRAM (wb2axi) port.
// Round-robin between the compute tile (m0) and a secondary requester (m1).
// Ownership lasts for the whole Wishbone cycle (cyc high), bursts included.
// Optional slave-hang watchdog: define WB_ARB_TIMEOUT_EN to enable it.
module wb_ddr_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master 0: compute tile external memory port
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [2:0]              m0_cti_i,
  input  logic [1:0]              m0_bte_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  // master 1: debug / DMA requester
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [2:0]              m1_cti_i,
  input  logic [1:0]              m1_bte_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  // shared slave port (wb2axi)
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  // 0: m0 wins a tie, 1: m1 wins a tie
  logic   r_prio;
  // abort flag and one-cycle watchdog error (tied low without the watchdog)
  logic   w_abort;
  logic   w_tmo_hit;

  // State register; async reset drops any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Round-robin pointer: hand priority to the other master when the owner finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if ((r_state == ST_OWN0) && !m0_cyc_i) begin
      r_prio <= 1'b1;
    end else if ((r_state == ST_OWN1) && !m1_cyc_i) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= r_prio;
    end
  end

  // Next-state: grant from IDLE only, hold ownership while the owner keeps cyc high
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next_state = r_prio ? ST_OWN1 : ST_OWN0;
        end else if (m0_cyc_i) begin
          w_next_state = ST_OWN0;
        end else if (m1_cyc_i) begin
          w_next_state = ST_OWN1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (m0_cyc_i) begin
          w_next_state = ST_OWN0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (m1_cyc_i) begin
          w_next_state = ST_OWN1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: mirror the owner's request, route responses only to the owner
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = 3'b000;
    s_bte_o  = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    grant_o  = 2'b00;
    // read data is broadcast; only the owner sees an ack qualifying it
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    case (r_state)
      ST_OWN0: begin
        s_cyc_o  = m0_cyc_i & ~w_abort;
        s_stb_o  = m0_stb_i & ~w_abort;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i & ~w_abort;
        m0_err_o = (s_err_i & ~w_abort) | w_tmo_hit;
        m0_rty_o = s_rty_i & ~w_abort;
        grant_o  = 2'b01;
      end
      ST_OWN1: begin
        s_cyc_o  = m1_cyc_i & ~w_abort;
        s_stb_o  = m1_stb_i & ~w_abort;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i & ~w_abort;
        m1_err_o = (s_err_i & ~w_abort) | w_tmo_hit;
        m1_rty_o = s_rty_i & ~w_abort;
        grant_o  = 2'b10;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_abort;
  logic             w_own_cyc;
  logic             w_stb_live;
  logic             w_slv_resp;

  // Watchdog qualifiers: owner's cyc, live strobe, and any slave response
  always_comb begin
    w_own_cyc  = 1'b0;
    w_stb_live = 1'b0;
    w_slv_resp = s_ack_i | s_err_i | s_rty_i;
    case (r_state)
      ST_OWN0: begin
        w_own_cyc  = m0_cyc_i;
        w_stb_live = m0_stb_i & ~r_abort;
      end
      ST_OWN1: begin
        w_own_cyc  = m1_cyc_i;
        w_stb_live = m1_stb_i & ~r_abort;
      end
      default: begin
        w_own_cyc  = 1'b0;
        w_stb_live = 1'b0;
      end
    endcase
    if (w_stb_live && !w_slv_resp && (r_tmo_cnt == TMO_LAST)) begin
      w_tmo_hit = 1'b1;
    end else begin
      w_tmo_hit = 1'b0;
    end
  end

  // Wait counter: runs on an unanswered strobe, clears on response or between owners
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_IDLE) || r_abort || w_slv_resp || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else if (w_stb_live) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  // Abort flag: set by the watchdog, held until the owner ends its cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
    end else if (!w_own_cyc) begin
      r_abort <= 1'b0;
    end else if (w_tmo_hit) begin
      r_abort <= 1'b1;
    end else begin
      r_abort <= r_abort;
    end
  end

  assign w_abort = r_abort;
`else
  // without the watchdog a hung slave simply stalls the owner
  logic w_unused_tmo;
  assign w_abort      = 1'b0;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 32'd0);
`endif

endmodule
